// File: rtl/tick_burst_gen_if.sv
// Control/status bundle between a burst controller (master) and tick_burst_gen (slave).
// The master drives the time base, the command and the lengths; the slave reports status.
interface tick_burst_gen_if #(
    parameter int CNT_W = 8
);
    logic             tick_i;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] burst_len;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;

    modport master (
        output tick_i, start, abort, burst_len, high_len, low_len,
        input  pulse_out, busy, done, pulses_sent
    );

    modport slave (
        input  tick_i, start, abort, burst_len, high_len, low_len,
        output pulse_out, busy, done, pulses_sent
    );
endinterface

// File: rtl/tick_burst_gen.sv
// Emits a burst of tick-timed pulses on command, with start/busy/done handshake and abort.
// All outputs are decoded from registered state, so none of them depend combinationally on inputs.
module tick_burst_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    tick_burst_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_burst;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_low;

    state_t           w_nextState;
    logic [CNT_W-1:0] w_nextCnt;
    logic [CNT_W-1:0] w_nextSent;
    logic [CNT_W-1:0] w_sentInc;
    logic             w_load;

    assign w_sentInc = r_sent + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sent  <= '0;
            r_burst <= '0;
            r_high  <= '0;
            r_low   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_sent  <= w_nextSent;
            if (w_load) begin
                r_burst <= bus.burst_len;
                r_high  <= bus.high_len;
                // A zero low length is stored as one tick so the LOW countdown always terminates
                r_low   <= (bus.low_len == '0) ? CNT_W'(1) : bus.low_len;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextSent  = r_sent;
        w_load      = 1'b0;

        if (bus.abort) begin
            w_nextState = S_IDLE;
            w_nextCnt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_load     = 1'b1;
                        w_nextSent = '0;
                        if (bus.burst_len == '0 || bus.high_len == '0) begin
                            w_nextState = S_DONE;
                            w_nextCnt   = '0;
                        end else begin
                            w_nextState = S_HIGH;
                            w_nextCnt   = bus.high_len;
                        end
                    end
                end
                S_HIGH: begin
                    if (bus.tick_i) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_nextSent = w_sentInc;
                            if (w_sentInc == r_burst) begin
                                w_nextState = S_DONE;
                                w_nextCnt   = '0;
                            end else begin
                                w_nextState = S_LOW;
                                w_nextCnt   = r_low;
                            end
                        end else begin
                            w_nextCnt = r_cnt - 1'b1;
                        end
                    end
                end
                S_LOW: begin
                    if (bus.tick_i) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_nextState = S_HIGH;
                            w_nextCnt   = r_high;
                        end else begin
                            w_nextCnt = r_cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_nextState = S_IDLE;
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    assign bus.pulse_out   = (r_state == S_HIGH);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.pulses_sent = r_sent;
endmodule

// File: tb/tb_tick_burst_gen.sv
// Bench for tick_burst_gen: expected traces come from a phase-list model of the burst
// (alternating high/low phase lengths in ticks), compared cycle by cycle at the falling edge.
module tb_tick_burst_gen;
    localparam int CNT_W = 8;
    localparam int MAXC  = 4096;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic             tickPat [MAXC];
    logic [CNT_W+2:0] expVec  [MAXC];

    tick_burst_gen_if #(.CNT_W(CNT_W)) bif ();

    tick_burst_gen #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W+2:0] obsVec();
        return {bif.pulse_out, bif.busy, bif.done, bif.pulses_sent};
    endfunction

    // expVec[j] is the {pulse,busy,done,sent} seen after the j-th edge following the start edge
    function automatic int buildExpected(int b, int h, int l);
        int phases[$];
        int idx  = 0;
        int used = 0;
        int sent = 0;
        if (b == 0 || h == 0) begin
            expVec[0] = {3'b011, CNT_W'(0)};
            expVec[1] = {3'b000, CNT_W'(0)};
            return 2;
        end
        for (int p = 0; p < b; p++) begin
            phases.push_back(h);
            if (p < b - 1) phases.push_back((l == 0) ? 1 : l);
        end
        expVec[0] = {3'b110, CNT_W'(0)};
        for (int j = 1; j < MAXC - 1; j++) begin
            if (tickPat[j]) begin
                used++;
                if (used == phases[idx]) begin
                    if (idx % 2 == 0) sent++;
                    idx++;
                    used = 0;
                end
            end
            if (idx == phases.size()) begin
                expVec[j]     = {3'b011, CNT_W'(sent)};
                expVec[j + 1] = {3'b000, CNT_W'(sent)};
                return j + 2;
            end
            expVec[j] = {(idx % 2 == 0), 2'b10, CNT_W'(sent)};
        end
        return MAXC - 1;
    endfunction

    task automatic startBurst(int b, int h, int l);
        bif.burst_len = CNT_W'(b);
        bif.high_len  = CNT_W'(h);
        bif.low_len   = CNT_W'(l);
        bif.start     = 1'b1;
        bif.abort     = 1'b0;
        bif.tick_i    = tickPat[0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.tick_i = 1'b0; bif.start = 1'b0; bif.abort = 1'b0;
        bif.burst_len = '0; bif.high_len = '0; bif.low_len = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (obsVec() !== {3'b000, CNT_W'(0)}) begin
            errors++;
            $display("[TB] FAIL reset_state got %b want %b", obsVec(), {3'b000, CNT_W'(0)});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int last;
        int doneCount = 0;
        for (int j = 0; j < MAXC; j++) tickPat[j] = (j % 3 == 0);
        last = buildExpected(3, 2, 1);
        @(negedge clk);
        startBurst(3, 2, 1);
        for (int j = 0; j < last; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec() !== expVec[j]) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d got %b want %b", j, obsVec(), expVec[j]);
            end
            if (bif.done) doneCount++;
            bif.start  = 1'b0;
            bif.tick_i = tickPat[j + 1];
        end
        checks++;
        if (doneCount != 1 || bif.pulses_sent !== CNT_W'(3) || bif.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_summary got done=%0d sent=%0d busy=%b want 1 3 0",
                     doneCount, bif.pulses_sent, bif.busy);
        end
    endtask

    task automatic test_zero_burst();
        int last;
        for (int j = 0; j < MAXC; j++) tickPat[j] = 1'($urandom_range(0, 1));
        last = buildExpected(0, 3, 2);
        @(negedge clk);
        startBurst(0, 3, 2);
        for (int j = 0; j < last + 2; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec() !== expVec[(j < last) ? j : last - 1]) begin
                errors++;
                $display("[TB] FAIL zero_burst_cycle%0d got %b want %b", j, obsVec(),
                         expVec[(j < last) ? j : last - 1]);
            end
            bif.start  = 1'b0;
            bif.tick_i = tickPat[j + 1];
        end
    endtask

    task automatic test_tied_tick();
        int last;
        logic [2:0] seq [4] = '{3'b110, 3'b010, 3'b110, 3'b011};
        for (int j = 0; j < MAXC; j++) tickPat[j] = 1'b1;
        last = buildExpected(2, 1, 0);
        @(negedge clk);
        startBurst(2, 1, 0);
        for (int j = 0; j < last; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec() !== expVec[j] || (j < 4 && obsVec() >> CNT_W !== seq[j])) begin
                errors++;
                $display("[TB] FAIL tied_tick_cycle%0d got %b want %b", j, obsVec(), expVec[j]);
            end
            bif.start  = 1'b0;
            bif.tick_i = 1'b1;
        end
    endtask

    task automatic test_random_busy_start();
        for (int n = 0; n < 8; n++) begin
            int b = $urandom_range(1, 5);
            int h = $urandom_range(1, 4);
            int l = $urandom_range(0, 3);
            int last;
            for (int j = 0; j < MAXC; j++) tickPat[j] = ($urandom_range(0, 2) == 0);
            last = buildExpected(b, h, l);
            @(negedge clk);
            startBurst(b, h, l);
            for (int j = 0; j < last; j++) begin
                @(negedge clk);
                checks++;
                if (obsVec() !== expVec[j]) begin
                    errors++;
                    $display("[TB] FAIL random%0d_cycle%0d got %b want %b", n, j, obsVec(), expVec[j]);
                end
                bif.tick_i    = tickPat[j + 1];
                bif.start     = (j + 1 <= last - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                bif.burst_len = CNT_W'($urandom);
                bif.high_len  = CNT_W'($urandom);
                bif.low_len   = CNT_W'($urandom);
            end
            bif.start = 1'b0;
        end
    endtask

    task automatic test_abort();
        for (int j = 0; j < MAXC; j++) tickPat[j] = 1'b1;
        void'(buildExpected(4, 3, 1));
        @(negedge clk);
        startBurst(4, 3, 1);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec() !== expVec[j]) begin
                errors++;
                $display("[TB] FAIL abort_run_cycle%0d got %b want %b", j, obsVec(), expVec[j]);
            end
            bif.start  = 1'b0;
            bif.tick_i = 1'b1;
        end
        bif.abort = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec() !== {3'b000, CNT_W'(1)}) begin
                errors++;
                $display("[TB] FAIL abort_idle%0d got %b want %b", j, obsVec(), {3'b000, CNT_W'(1)});
            end
            bif.abort = 1'b0;
        end
        bif.start = 1'b1; bif.abort = 1'b1;
        bif.burst_len = CNT_W'(3); bif.high_len = CNT_W'(1); bif.low_len = CNT_W'(1);
        @(negedge clk);
        checks++;
        if (obsVec() !== {3'b000, CNT_W'(1)}) begin
            errors++;
            $display("[TB] FAIL start_with_abort got %b want %b", obsVec(), {3'b000, CNT_W'(1)});
        end
        bif.start = 1'b0; bif.abort = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int last;
        for (int j = 0; j < MAXC; j++) tickPat[j] = 1'b1;
        void'(buildExpected(3, 2, 3));
        @(negedge clk);
        startBurst(3, 2, 3);
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec() !== expVec[j]) begin
                errors++;
                $display("[TB] FAIL reset_mid_run_cycle%0d got %b want %b", j, obsVec(), expVec[j]);
            end
            bif.start  = 1'b0;
            bif.tick_i = 1'b1;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obsVec() !== {3'b000, CNT_W'(0)}) begin
            errors++;
            $display("[TB] FAIL reset_mid_async got %b want %b", obsVec(), {3'b000, CNT_W'(0)});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < MAXC; j++) tickPat[j] = ($urandom_range(0, 1) == 0);
        last = buildExpected(2, 3, 2);
        @(negedge clk);
        startBurst(2, 3, 2);
        for (int j = 0; j < last; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec() !== expVec[j]) begin
                errors++;
                $display("[TB] FAIL after_reset_cycle%0d got %b want %b", j, obsVec(), expVec[j]);
            end
            bif.start  = 1'b0;
            bif.tick_i = tickPat[j + 1];
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_burst();
        test_tied_tick();
        test_random_busy_start();
        test_abort();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
